fw_loader: RTL and testbench
============================

# fw_loader

UART firmware bootloader for the single-cycle RISC-V system. It sits directly upstream of the instruction ROM. It receives a framed program image over a serial line, assembles little-endian 32-bit words and writes them through the ROM's write port. It holds the core in reset until a complete image with a valid checksum has been stored.

## Interface
Parameters:
- CLK_DIV, 868: clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, 8: ROM word-address width; ROM_WORDS = 2**ADDR_W, maximum 256.

Ports:
- clk  input  1  system clock. One clock domain; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  UART serial input, 8N1, idle high; asynchronous to clk.
- rom_we  output  1  ROM write strobe, one cycle per word.
- rom_addr  output  ADDR_W  ROM word address of the current write.
- rom_wdata  output  32  instruction word to write.
- core_reset  output  1  active-high reset to the core; 1 while loading.
- busy  output  1  frame in progress (state not IDLE and not DONE).
- error  output  1  sticky error flag; cleared by the next accepted sync byte or by reset.

## Operation
- Frame format: sync 0xA5, length byte L (image = L+1 words), 4*(L+1) data bytes (LSB first per word), then a checksum byte equal to the XOR of all data bytes.
- UART receiver:
  - rx passes through a 2-flop synchronizer.
  - A falling edge in idle starts a byte. The start bit is re-sampled at CLK_DIV/2; if it reads high, it is discarded as a glitch.
  - The 8 data bits are sampled every CLK_DIV cycles after that, LSB first.
  - If the stop bit is 1, the receiver emits an internal byte_valid pulse for one cycle.
  - If the stop bit is 0, it emits frame_err instead.
- FSM states: IDLE, LEN, DATA, CSUM, DONE.
  - IDLE: a byte of 0xA5 → LEN, clears error, rom_addr=0, csum=0. Any other byte is ignored.
  - LEN: stores L. If L ≥ ROM_WORDS → error=1, go to IDLE. Otherwise → DATA.
  - DATA: shifts each byte into a word register at byte lane (byte count mod 4) and XORs it into csum. After the 4th byte of a word: rom_we pulse, then rom_addr increments. After word L is written → CSUM.
  - CSUM: byte == csum → DONE. Otherwise error=1 → IDLE.
  - DONE: core_reset=0. Further behaviour is set under Configuration.
- A frame_err in LEN, DATA or CSUM sets error=1 and returns to IDLE. A frame_err in IDLE or DONE is ignored.
- ROM words already written before an error are not rolled back. core_reset stays 1, so the partial image never executes.
- rom_addr is not incremented past word L. ROM addresses above L are left untouched.

## Timing
- Reset values: rom_we=0, rom_addr=0, rom_wdata=0, core_reset=1, busy=0, error=0. The FSM goes to IDLE and the receiver to idle. Reset applies immediately and asynchronously; release is synchronous to clk.
- byte_valid occurs 1 cycle after the stop-bit sample.
- rom_we is high for exactly 1 cycle, in the cycle after byte_valid of a word's 4th byte. rom_addr and rom_wdata are stable during that cycle; rom_addr increments on the following edge.
- core_reset falls 1 cycle after byte_valid of a matching checksum byte.
- error rises 1 cycle after the offending byte_valid or frame_err.
- Reset asserted mid-frame aborts the load. After release, a new frame starts at address 0.
- Back-to-back bytes with no idle gap are accepted. The receiver re-arms on the stop-bit sample.

## Configuration
- FW_LOADER_RELOAD_EN defined: in DONE, a sync byte 0xA5 reasserts core_reset in the cycle after its byte_valid, then the FSM goes to LEN for a fresh load.
- FW_LOADER_RELOAD_EN undefined: DONE is terminal. All rx traffic is ignored until reset, and core_reset stays 0.

## Test plan
All scenarios use CLK_DIV=4, ADDR_W=8 unless stated.
- Valid 2-word load: A5 01 13 00 50 00 93 00 10 00 C0 → rom_we pulses with (0, 0x00500013) then (1, 0x00100093). core_reset falls after byte C0; error=0.
- Bad checksum: same frame ending in C1 instead of C0 → both writes occur, error=1, core_reset stays 1, FSM in IDLE. A following valid frame clears error and reaches DONE.
- Junk before sync: 00 FF 5A, then the valid frame → the junk produces no writes and no error. Load completes as in the first scenario.
- Framing error: stop bit forced 0 on the 3rd data byte → error=1, no rom_we for word 0, returns to IDLE.
- Oversize length: with ADDR_W=4, send A5 10 → error=1, no rom_we.
- Reset mid-DATA, then a reload with and without the macro:
  - Pulling reset low after 5 data bytes → all outputs return to reset values.
  - After release, the valid frame writes from address 0.
  - A second A5 in DONE reasserts core_reset only when FW_LOADER_RELOAD_EN is defined.

Source files
------------

// File: rtl/fw_loader.sv
`default_nettype none
// ============================================================================
// Module   : fw_loader
// Brief    : UART firmware bootloader writing a checksummed image into the
//            instruction ROM; holds the core in reset until the load is valid.
//            Optional macro FW_LOADER_RELOAD_EN allows reloading from DONE.
// Revision : 1.0 - initial release
// ============================================================================
module fw_loader #(
    parameter int CLK_DIV = 868,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              error
);
    localparam int               ROM_WORDS = 1 << ADDR_W;
    localparam int               CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [8:0]       WORDS_9   = 9'(ROM_WORDS);
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    logic [2:0]        state_q, state_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        csum_q, csum_d;
    logic              core_reset_q, core_reset_d;
    logic              error_q, error_d;

    logic sync_hit, len_ok, last_byte;

    // ---------------- UART receiver ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF_M1) begin
                cnt_d      = '0;
                bit_d      = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == DIV_M1) begin
                cnt_d   = '0;
                shift_d = {rx_sync_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == DIV_M1) begin
                // Re-arm right at the stop sample so back-to-back bytes are caught
                cnt_d        = '0;
                rx_state_d   = RX_IDLE;
                byte_valid_d = rx_sync_q;
                frame_err_d  = !rx_sync_q;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- Frame FSM ----------------
    assign sync_hit  = byte_valid_q && (shift_q == SYNC_BYTE);
    assign len_ok    = {1'b0, shift_q} < WORDS_9;
    assign last_byte = (lane_q == 2'd3) && (addr_q == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sync_hit) state_d = ST_LEN;
            ST_LEN: begin
                if (frame_err_q)       state_d = ST_IDLE;
                else if (byte_valid_q) state_d = len_ok ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                if (frame_err_q)                    state_d = ST_IDLE;
                else if (byte_valid_q && last_byte) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (frame_err_q)       state_d = ST_IDLE;
                else if (byte_valid_q) state_d = (shift_q == csum_q) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
`ifdef FW_LOADER_RELOAD_EN
                if (sync_hit) state_d = ST_LEN;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rom_we_d     = 1'b0;
        addr_d       = addr_q;
        len_d        = len_q;
        word_d       = word_q;
        lane_d       = lane_q;
        csum_d       = csum_q;
        core_reset_d = core_reset_q;
        error_d      = error_q;
        // Advance after each write, but never beyond the last word of the image
        if (rom_we_q && (addr_q != len_q)) addr_d = addr_q + 1'b1;
        case (state_q)
            ST_IDLE: if (sync_hit) begin
                error_d = 1'b0;
                addr_d  = '0;
                csum_d  = '0;
                lane_d  = '0;
            end
            ST_LEN: begin
                if (frame_err_q) error_d = 1'b1;
                else if (byte_valid_q) begin
                    len_d = shift_q[ADDR_W-1:0];
                    if (!len_ok) error_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (frame_err_q) error_d = 1'b1;
                else if (byte_valid_q) begin
                    word_d[8*lane_q +: 8] = shift_q;
                    csum_d                = csum_q ^ shift_q;
                    lane_d                = lane_q + 1'b1;
                    rom_we_d              = (lane_q == 2'd3);
                end
            end
            ST_CSUM: begin
                if (frame_err_q) error_d = 1'b1;
                else if (byte_valid_q) begin
                    if (shift_q == csum_q) core_reset_d = 1'b0;
                    else                   error_d      = 1'b1;
                end
            end
            ST_DONE: begin
`ifdef FW_LOADER_RELOAD_EN
                if (sync_hit) begin
                    core_reset_d = 1'b1;
                    error_d      = 1'b0;
                    addr_d       = '0;
                    csum_d       = '0;
                    lane_d       = '0;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_we_q     <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            csum_q       <= '0;
            core_reset_q <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            rom_we_q     <= rom_we_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            csum_q       <= csum_d;
            core_reset_q <= core_reset_d;
            error_q      <= error_d;
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = addr_q;
    assign rom_wdata  = word_q;
    assign core_reset = core_reset_q;
    assign error      = error_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fw_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fw_loader
// Brief    : Randomized self-checking bench for fw_loader (ADDR_W=8 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fw_loader;
    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 8;
    localparam int SMALL_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_drv = 1'b1;
    logic to_small = 1'b0;
    logic rx_big, rx_small;

    logic              rom_we, core_reset, busy, error;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic               s_rom_we, s_core_reset, s_busy, s_error;
    logic [SMALL_W-1:0] s_rom_addr;
    logic [31:0]        s_rom_wdata;

    assign rx_big   = to_small ? 1'b1 : rx_drv;
    assign rx_small = to_small ? rx_drv : 1'b1;

    fw_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx(rx_big), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_wdata(rom_wdata), .core_reset(core_reset), .busy(busy), .error(error)
    );

    fw_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(SMALL_W)) dut_small (
        .clk(clk), .reset(reset), .rx(rx_small), .rom_we(s_rom_we), .rom_addr(s_rom_addr),
        .rom_wdata(s_rom_wdata), .core_reset(s_core_reset), .busy(s_busy), .error(s_error)
    );

    always #5 clk = ~clk;

    typedef logic [39:0] wr_t;   // {addr[7:0], data[31:0]}
    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] frame_q[$];
    logic [31:0] words[$];
    int         small_we = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         exp_reload;

    always @(negedge clk) begin
        if (rom_we)   got_q.push_back({rom_addr, rom_wdata});
        if (s_rom_we) small_we++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_we"},    64'(rom_we),     64'd0);
        check_val({tag, "_addr"},  64'(rom_addr),   64'd0);
        check_val({tag, "_wdata"}, 64'(rom_wdata),  64'd0);
        check_val({tag, "_crst"},  64'(core_reset), 64'd1);
        check_val({tag, "_busy"},  64'(busy),       64'd0);
        check_val({tag, "_err"},   64'(error),      64'd0);
    endtask

    // Caller is aligned to a falling clock edge
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // Image = words[0..l]; checksum is XOR of all data bytes, optionally corrupted
    task automatic make_frame(input int l, input bit bad_csum);
        logic [7:0] cs;
        cs = 8'h00;
        frame_q = {};
        exp_q   = {};
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(l));
        for (int i = 0; i <= l; i++) begin
            exp_q.push_back({8'(i), words[i]});
            for (int k = 0; k < 4; k++) begin
                frame_q.push_back(words[i][8*k +: 8]);
                cs = cs ^ words[i][8*k +: 8];
            end
        end
        frame_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    endtask

    task automatic random_words(input int n);
        words = {};
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], 1'b1);
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int base);
        check_val({tag, "_cnt"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
            check_val({tag, "_wr"}, 64'(got_q[base + i]), 64'(exp_q[i]));
    endtask

    task automatic check_status(input string tag, input bit exp_err, input bit exp_crst);
        check_val({tag, "_err"},  64'(error),      64'(exp_err));
        check_val({tag, "_crst"}, 64'(core_reset), 64'(exp_crst));
        check_val({tag, "_busy"}, 64'(busy),       64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base;
        int l;
        bit bad;
`ifdef FW_LOADER_RELOAD_EN
        exp_reload = 1'b1;
`else
        exp_reload = 1'b0;
`endif
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Start-bit glitch, junk, then the reference 2-word frame
        base = got_q.size();
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check_val("junk_err", 64'(error), 64'd0);
        words = {32'h00500013, 32'h00100093};
        make_frame(1, 1'b0);
        check_val("ref_csum", 64'(frame_q[frame_q.size()-1]), 64'hC0);
        send_frame(0);
        check_writes("ref", base);
        check_status("ref", 1'b0, 1'b0);

        // Sync byte while DONE
        base = got_q.size();
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check_val("done_sync_crst", 64'(core_reset), 64'(exp_reload));
        random_words(1);
        make_frame(0, 1'b0);
        void'(frame_q.pop_front());
        send_frame(2);
        if (!exp_reload) exp_q = {};
        check_writes("done_tail", base);
        check_val("done_tail_crst", 64'(core_reset), 64'd0);

        // Bad checksum, then recovery
        do_reset();
        base = got_q.size();
        words = {32'h00500013, 32'h00100093};
        make_frame(1, 1'b1);
        check_val("bad_csum_byte", 64'(frame_q[frame_q.size()-1]), 64'hC1);
        send_frame(1);
        check_writes("badcs", base);
        check_status("badcs", 1'b1, 1'b1);
        base = got_q.size();
        make_frame(1, 1'b0);
        send_frame(1);
        check_writes("recov", base);
        check_status("recov", 1'b0, 1'b0);

        // Framing error on the 3rd data byte
        do_reset();
        base = got_q.size();
        random_words(2);
        make_frame(1, 1'b0);
        send_byte(frame_q[0], 1'b1);
        send_byte(frame_q[1], 1'b1);
        repeat (4) @(negedge clk);
        check_val("ferr_busy_mid", 64'(busy), 64'd1);
        send_byte(frame_q[2], 1'b1);
        send_byte(frame_q[3], 1'b1);
        send_byte(frame_q[4], 1'b0);
        repeat (6) @(negedge clk);
        exp_q = {};
        check_writes("ferr", base);
        check_status("ferr", 1'b1, 1'b1);

        // Reset after 5 data bytes, then a clean load from address 0
        do_reset();
        random_words(3);
        make_frame(2, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(frame_q[i], 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        base = got_q.size();
        send_frame(2);
        check_writes("after_rst", base);
        check_status("after_rst", 1'b0, 1'b0);

        // Randomized frames with optional junk and checksum corruption
        for (int it = 0; it < 16; it++) begin
            do_reset();
            base = got_q.size();
            repeat ($urandom_range(2, 0)) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h3C;
                send_byte(j, 1'b1);
            end
            l   = $urandom_range(5, 0);
            bad = ($urandom_range(3, 0) == 0);
            random_words(l + 1);
            make_frame(l, bad);
            send_frame(3);
            check_writes("rnd", base);
            check_status("rnd", bad, bad);
        end

        // Length boundary on a 16-word ROM
        do_reset();
        to_small = 1'b1;
        base = small_we;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        repeat (6) @(negedge clk);
        check_val("over_err",  64'(s_error),        64'd1);
        check_val("over_busy", 64'(s_busy),         64'd0);
        check_val("over_we",   64'(small_we - base), 64'd0);
        check_val("over_crst", 64'(s_core_reset),   64'd1);
        random_words(16);
        make_frame(15, 1'b0);
        send_frame(0);
        check_val("max_we",   64'(small_we - base), 64'd16);
        check_val("max_err",  64'(s_error),        64'd0);
        check_val("max_crst", 64'(s_core_reset),   64'd0);
        check_val("max_addr", 64'(s_rom_addr),     64'd15);
        to_small = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
